// File: rtl/range_seq_sender_pkg.sv
// Shared types and constants for the range_seq_sender burst transmitter.
package range_seq_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEND_FIRST = 2'd1,
        SEND_MID   = 2'd2,
        SEND_LAST  = 2'd3
    } state_t;

    // A legal frame needs distinct first (go) and last (finish) samples.
    localparam int MIN_BURST = 2;

endpackage

// File: rtl/range_seq_sender_if.sv
// Host/receiver-facing signal bundle of range_seq_sender.
// RANGE_SEQ_SENDER_EXPECT_EN adds the expected_range/expected_valid scoreboard outputs.
interface range_seq_sender_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             clear;
    logic             send;
    logic             busy;
    logic             done;
    logic [CW-1:0]    count;
    logic             go;
    logic             finish;
    logic [WIDTH-1:0] data_out;
    logic             error;
`ifdef RANGE_SEQ_SENDER_EXPECT_EN
    logic [WIDTH-1:0] expected_range;
    logic             expected_valid;
`endif

    modport master (
        output wr_en, wr_data, clear, send,
        input  busy, done, count, go, finish, data_out, error
`ifdef RANGE_SEQ_SENDER_EXPECT_EN
        , input expected_range, expected_valid
`endif
    );

    modport slave (
        input  wr_en, wr_data, clear, send,
        output busy, done, count, go, finish, data_out, error
`ifdef RANGE_SEQ_SENDER_EXPECT_EN
        , output expected_range, expected_valid
`endif
    );

endinterface

// File: rtl/range_seq_sender_buffer.sv
// Sample buffer for range_seq_sender: append-only register array with
// fill count, clear and a combinational read port addressed by the FSM.
module range_seq_buffer
    import range_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       clear,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic [WIDTH-1:0]           rd_data
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic             wr_accept;

    assign full      = (count_reg == CW'(DEPTH));
    assign wr_accept = wr_en && !full && !clear;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (wr_accept) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            mem_reg[count_reg[IW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem_reg[rd_idx];
    assign count   = count_reg;

endmodule

// File: rtl/range_seq_sender.sv
// Burst transmitter: replays the buffered samples one per cycle framed by go/finish.
// RANGE_SEQ_SENDER_EXPECT_EN adds running min/max tracking and expected_range output.
module range_seq_sender
    import range_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    range_seq_sender_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    state_t           state_reg, state_next;
    logic [IW-1:0]    index_reg, index_next;
    logic             go_reg, go_next;
    logic             finish_reg, finish_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             error_reg, error_next;

    logic             buf_wr_en;
    logic             buf_clear;
    logic [IW-1:0]    rd_idx;
    logic [WIDTH-1:0] rd_data;
    logic [CW-1:0]    count;
    logic             full;
    logic             send_ok;
    logic             last_mid;

    range_seq_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buffer (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (buf_wr_en),
        .wr_data (bus.wr_data),
        .clear   (buf_clear),
        .rd_idx  (rd_idx),
        .count   (count),
        .full    (full),
        .rd_data (rd_data)
    );

    assign send_ok  = (count >= CW'(MIN_BURST));
    assign last_mid = ({1'b0, index_reg} == (count - 1'b1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:       if (bus.send && send_ok) state_next = SEND_FIRST;
            SEND_FIRST: state_next = (count == CW'(MIN_BURST)) ? SEND_LAST : SEND_MID;
            SEND_MID:   if (last_mid) state_next = SEND_LAST;
            SEND_LAST:  state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Send outranks clear/write in IDLE: it is judged on the pre-write count.
    always_comb begin
        go_next     = 1'b0;
        finish_next = 1'b0;
        data_next   = data_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        error_next  = error_reg;
        index_next  = index_reg;
        rd_idx      = '0;
        buf_wr_en   = 1'b0;
        buf_clear   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.send) begin
                    if (send_ok) begin
                        go_next   = 1'b1;
                        data_next = rd_data;
                        busy_next = 1'b1;
                    end else begin
                        error_next = 1'b1;
                    end
                end else if (bus.clear) begin
                    buf_clear  = 1'b1;
                    error_next = 1'b0;
                end else if (bus.wr_en) begin
                    if (full) error_next = 1'b1;
                    else      buf_wr_en  = 1'b1;
                end
            end
            SEND_FIRST: begin
                rd_idx    = IW'(1);
                data_next = rd_data;
                if (count == CW'(MIN_BURST)) finish_next = 1'b1;
                else                         index_next  = IW'(2);
            end
            SEND_MID: begin
                rd_idx    = index_reg;
                data_next = rd_data;
                if (last_mid) finish_next = 1'b1;
                else          index_next  = index_reg + 1'b1;
            end
            SEND_LAST: begin
                data_next = '0;
                busy_next = 1'b0;
                done_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            index_reg  <= '0;
            go_reg     <= 1'b0;
            finish_reg <= 1'b0;
            data_reg   <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            index_reg  <= index_next;
            go_reg     <= go_next;
            finish_reg <= finish_next;
            data_reg   <= data_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            error_reg  <= error_next;
        end
    end

    assign bus.go       = go_reg;
    assign bus.finish   = finish_reg;
    assign bus.data_out = data_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.error    = error_reg;
    assign bus.count    = count;

`ifdef RANGE_SEQ_SENDER_EXPECT_EN
    logic [WIDTH-1:0] min_reg, max_reg;
    logic [WIDTH-1:0] exp_range_reg;
    logic             exp_valid_reg;

    // rd_data is the sample being launched on this edge in every sending state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            min_reg       <= '0;
            max_reg       <= '0;
            exp_range_reg <= '0;
            exp_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.send && send_ok) begin
                        min_reg       <= rd_data;
                        max_reg       <= rd_data;
                        exp_range_reg <= '0;
                        exp_valid_reg <= 1'b0;
                    end
                end
                SEND_FIRST, SEND_MID: begin
                    if (rd_data < min_reg) min_reg <= rd_data;
                    if (rd_data > max_reg) max_reg <= rd_data;
                end
                SEND_LAST: begin
                    exp_range_reg <= max_reg - min_reg;
                    exp_valid_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.expected_range = exp_range_reg;
    assign bus.expected_valid = exp_valid_reg;
`endif

endmodule

// File: tb/tb_range_seq_sender.sv
// Directed self-checking bench for range_seq_sender (WIDTH=8, DEPTH=8).
module tb_range_seq_sender;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    range_seq_sender_if #(.WIDTH(8), .DEPTH(8)) bus ();

    range_seq_sender #(.WIDTH(8), .DEPTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       clear;
        logic       send;
        logic       go;
        logic       finish;
        logic [7:0] data;
        logic       busy;
        logic       done;
        logic [3:0] count;
        logic       error;
    } vec_t;

    vec_t vecs[$];
    int   t1_done_idx;

    function automatic vec_t v(input logic we, input logic [7:0] wd, input logic cl,
                               input logic sd, input logic g, input logic f,
                               input logic [7:0] d, input logic b, input logic dn,
                               input logic [3:0] c, input logic e);
        vec_t r;
        r.wr_en = we; r.wr_data = wd; r.clear = cl; r.send = sd;
        r.go = g; r.finish = f; r.data = d; r.busy = b; r.done = dn;
        r.count = c; r.error = e;
        return r;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic we, input logic [7:0] wd, input logic cl, input logic sd);
        bus.wr_en = we; bus.wr_data = wd; bus.clear = cl; bus.send = sd;
    endtask

    task automatic check_outs(input string name, input int idx, input logic g, input logic f,
                              input logic [7:0] d, input logic b, input logic dn,
                              input logic [3:0] c, input logic e);
        check({name, "_go"},     idx, 32'(bus.go),       32'(g));
        check({name, "_finish"}, idx, 32'(bus.finish),   32'(f));
        check({name, "_data"},   idx, 32'(bus.data_out), 32'(d));
        check({name, "_busy"},   idx, 32'(bus.busy),     32'(b));
        check({name, "_done"},   idx, 32'(bus.done),     32'(dn));
        check({name, "_count"},  idx, 32'(bus.count),    32'(c));
        check({name, "_error"},  idx, 32'(bus.error),    32'(e));
        $display("%s[%0d]: go=%0b finish=%0b data=0x%02h busy=%0b done=%0b count=%0d error=%0b",
                 name, idx, bus.go, bus.finish, bus.data_out, bus.busy, bus.done,
                 bus.count, bus.error);
    endtask

    initial begin
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Test 1: 5,9,2,7 burst
        vecs.push_back(v(1, 8'd5, 0, 0,  0, 0, 8'd0, 0, 0, 4'd1, 0));
        vecs.push_back(v(1, 8'd9, 0, 0,  0, 0, 8'd0, 0, 0, 4'd2, 0));
        vecs.push_back(v(1, 8'd2, 0, 0,  0, 0, 8'd0, 0, 0, 4'd3, 0));
        vecs.push_back(v(1, 8'd7, 0, 0,  0, 0, 8'd0, 0, 0, 4'd4, 0));
        vecs.push_back(v(0, 8'd0, 0, 1,  1, 0, 8'd5, 1, 0, 4'd4, 0));
        vecs.push_back(v(0, 8'd0, 0, 0,  0, 0, 8'd9, 1, 0, 4'd4, 0));
        vecs.push_back(v(0, 8'd0, 0, 0,  0, 0, 8'd2, 1, 0, 4'd4, 0));
        vecs.push_back(v(0, 8'd0, 0, 0,  0, 1, 8'd7, 1, 0, 4'd4, 0));
        t1_done_idx = vecs.size();
        vecs.push_back(v(0, 8'd0, 0, 0,  0, 0, 8'd0, 0, 1, 4'd4, 0));
        vecs.push_back(v(0, 8'd0, 0, 0,  0, 0, 8'd0, 0, 0, 4'd4, 0));
        // Test 2: minimum burst 3,3
        vecs.push_back(v(0, 8'd0, 1, 0,  0, 0, 8'd0, 0, 0, 4'd0, 0));
        vecs.push_back(v(1, 8'd3, 0, 0,  0, 0, 8'd0, 0, 0, 4'd1, 0));
        vecs.push_back(v(1, 8'd3, 0, 0,  0, 0, 8'd0, 0, 0, 4'd2, 0));
        vecs.push_back(v(0, 8'd0, 0, 1,  1, 0, 8'd3, 1, 0, 4'd2, 0));
        vecs.push_back(v(0, 8'd0, 0, 0,  0, 1, 8'd3, 1, 0, 4'd2, 0));
        vecs.push_back(v(0, 8'd0, 0, 0,  0, 0, 8'd0, 0, 1, 4'd2, 0));
        vecs.push_back(v(0, 8'd0, 0, 0,  0, 0, 8'd0, 0, 0, 4'd2, 0));
        // Test 3: single-sample send is illegal; clear recovers
        vecs.push_back(v(0, 8'd0, 1, 0,  0, 0, 8'd0, 0, 0, 4'd0, 0));
        vecs.push_back(v(1, 8'd1, 0, 0,  0, 0, 8'd0, 0, 0, 4'd1, 0));
        vecs.push_back(v(0, 8'd0, 0, 1,  0, 0, 8'd0, 0, 0, 4'd1, 1));
        vecs.push_back(v(0, 8'd0, 0, 0,  0, 0, 8'd0, 0, 0, 4'd1, 1));
        vecs.push_back(v(0, 8'd0, 1, 0,  0, 0, 8'd0, 0, 0, 4'd0, 0));

        repeat (2) @(posedge clock);
        #1;
        check_outs("reset_hold", 0, 0, 0, 8'd0, 0, 0, 4'd0, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_outs("reset_rel", 0, 0, 0, 8'd0, 0, 0, 4'd0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].wr_en, vecs[i].wr_data, vecs[i].clear, vecs[i].send);
            tick();
            check_outs("vec", i, vecs[i].go, vecs[i].finish, vecs[i].data,
                       vecs[i].busy, vecs[i].done, vecs[i].count, vecs[i].error);
`ifdef RANGE_SEQ_SENDER_EXPECT_EN
            if (i == t1_done_idx) begin
                check("exp_range", i, 32'(bus.expected_range), 32'd7);
                check("exp_valid", i, 32'(bus.expected_valid), 32'd1);
            end
`endif
        end
        drive(0, 8'd0, 0, 0);

        // Test 4: overflow at DEPTH=8, ninth value must never be sent
        for (int i = 0; i < 9; i++) begin
            drive(1, 8'(10 + i), 0, 0);
            tick();
            check_outs("ovf_wr", i, 0, 0, 8'd0, 0, 0, (i < 8) ? 4'(i + 1) : 4'd8, (i == 8));
        end
        drive(0, 8'd0, 0, 1);
        tick();
        drive(0, 8'd0, 0, 0);
        check_outs("ovf_tx", 0, 1, 0, 8'd10, 1, 0, 4'd8, 1);
        for (int k = 1; k < 8; k++) begin
            tick();
            check_outs("ovf_tx", k, 0, (k == 7), 8'(10 + k), 1, 0, 4'd8, 1);
        end
        tick();
        check_outs("ovf_done", 0, 0, 0, 8'd0, 0, 1, 4'd8, 1);

        // Test 5: inputs ignored while busy, then immediate replay
        drive(0, 8'd0, 1, 0); tick();
        drive(1, 8'hFF, 0, 0); tick();
        drive(1, 8'h00, 0, 0); tick();
        drive(1, 8'h80, 0, 0); tick();
        check_outs("busy_fill", 0, 0, 0, 8'd0, 0, 0, 4'd3, 0);
        drive(0, 8'd0, 0, 1); tick();
        check_outs("busy_tx", 0, 1, 0, 8'hFF, 1, 0, 4'd3, 0);
        drive(1, 8'h55, 0, 1); tick();
        check_outs("busy_tx", 1, 0, 0, 8'h00, 1, 0, 4'd3, 0);
        drive(1, 8'h55, 1, 1); tick();
        check_outs("busy_tx", 2, 0, 1, 8'h80, 1, 0, 4'd3, 0);
        drive(0, 8'd0, 0, 0); tick();
        check_outs("busy_done", 0, 0, 0, 8'd0, 0, 1, 4'd3, 0);
        drive(0, 8'd0, 0, 1); tick();
        drive(0, 8'd0, 0, 0);
        check_outs("replay", 0, 1, 0, 8'hFF, 1, 0, 4'd3, 0);
        tick();
        check_outs("replay", 1, 0, 0, 8'h00, 1, 0, 4'd3, 0);
        tick();
        check_outs("replay", 2, 0, 1, 8'h80, 1, 0, 4'd3, 0);
        tick();
        check_outs("replay_done", 0, 0, 0, 8'd0, 0, 1, 4'd3, 0);

        // Test 6: asynchronous reset in cycle 2 of a 6-sample burst
        drive(0, 8'd0, 1, 0); tick();
        for (int i = 0; i < 6; i++) begin
            drive(1, 8'(21 + i), 0, 0);
            tick();
        end
        drive(0, 8'd0, 0, 1); tick();
        drive(0, 8'd0, 0, 0);
        check_outs("rst_burst", 0, 1, 0, 8'd21, 1, 0, 4'd6, 0);
        tick();
        check_outs("rst_burst", 1, 0, 0, 8'd22, 1, 0, 4'd6, 0);
        tick();
        check_outs("rst_burst", 2, 0, 0, 8'd23, 1, 0, 4'd6, 0);
        #2;
        reset = 1'b1;
        #1;
        check_outs("rst_async", 0, 0, 0, 8'd0, 0, 0, 4'd0, 0);
        @(negedge clock);
        reset = 1'b0;
        tick();
        check_outs("rst_after", 0, 0, 0, 8'd0, 0, 0, 4'd0, 0);
        tick();
        check_outs("rst_after", 1, 0, 0, 8'd0, 0, 0, 4'd0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Protocol guard: go and finish must never be high together.
    always @(negedge clock) begin
        if (!reset && bus.go && bus.finish) begin
            errors++;
            $display("FAIL go_finish_overlap: got go=1 finish=1, expected not both high");
        end
    end

endmodule
